// File: rtl/display_pkg.sv
// Shared constants and FSM encoding for the 8-digit multiplexed display scanner.
package display_pkg;
  localparam int DIGITS = 8;
  localparam int NIB_W  = 4;
  localparam int SEL_W  = 3;
  localparam int DATA_W = DIGITS * NIB_W;

  typedef enum logic {
    BLANKING = 1'b0,
    SHOWING  = 1'b1
  } scan_state_e;

  typedef logic [DIGITS-1:0][NIB_W-1:0] digits_t;
endpackage

// File: rtl/display_scanner_if.sv
// Value-load handshake plus the scanned digit outputs toward the 7-segment driver.
interface display_scanner_if;
  import display_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              lz_en;
  logic [NIB_W-1:0]  nib;
  logic [SEL_W-1:0]  sel;
  logic              blank;
  logic              frame_start;

  modport master (
    output in_valid, in_data, lz_en,
    input  in_ready, nib, sel, blank, frame_start
  );

  modport slave (
    input  in_valid, in_data, lz_en,
    output in_ready, nib, sel, blank, frame_start
  );
endinterface

// File: rtl/display_scanner_slot_timer.sv
// Free-running slot counter; tick marks the last cycle of each digit slot.
module slot_timer #(
  parameter  int DIV   = 50000,
  localparam int CNT_W = $clog2(DIV)
) (
  input  logic             clk,
  input  logic             rst,
  output logic [CNT_W-1:0] cnt,
  output logic             tick
);
  assign tick = (cnt == CNT_W'(DIV - 1));

  always_ff @(posedge clk) begin
    if (rst)       cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/display_scanner.sv
// Multiplexed 8-digit scanner: per-slot blanking, leading-zero suppression and
// frame-aligned double buffering so a displayed frame never mixes two values.
module display_scanner
  import display_pkg::*;
#(
  parameter int DIV   = 50000,
  parameter int BLANK = 16
) (
  input  logic              clk,
  input  logic              rst,
  display_scanner_if.slave  bus
);
  localparam int CNT_W = $clog2(DIV);

  logic [CNT_W-1:0] cnt;
  logic             tick;
  logic [SEL_W-1:0] sel_q;
  scan_state_e      state, state_nx;
  digits_t          shadow, active;
  logic             pending;
  logic             accept;
  logic             frame_end;
  logic [DIGITS-1:0] digit_zero;
  logic [DIGITS-1:0] zero_from;

  slot_timer #(.DIV(DIV)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .cnt  (cnt),
    .tick (tick)
  );

  assign frame_end = tick && (sel_q == SEL_W'(DIGITS - 1));
  assign accept    = bus.in_valid && !pending;

  always_ff @(posedge clk) begin
    if (rst)       sel_q <= '0;
    else if (tick) sel_q <= sel_q + 1'b1;
  end

  // state tracks cnt<BLANK; entering SHOWING one cycle early keeps it registered
  always_ff @(posedge clk) begin
    if (rst) state <= BLANKING;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      BLANKING: if (cnt == CNT_W'(BLANK - 1)) state_nx = SHOWING;
      SHOWING:  if (tick)                     state_nx = BLANKING;
      default:                                state_nx = BLANKING;
    endcase
  end

  // Swap only at the frame boundary; an accept in that same cycle waits a frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow  <= '0;
      active  <= '0;
      pending <= 1'b0;
    end else begin
      if (frame_end && pending) begin
        active  <= shadow;
        pending <= 1'b0;
      end
      if (accept) begin
        shadow  <= bus.in_data;
        pending <= 1'b1;
      end
    end
  end

  for (genvar k = 0; k < DIGITS; k++) begin : g_lz
    assign digit_zero[k] = (active[k] == '0);
    assign zero_from[k]  = &digit_zero[DIGITS-1:k];
  end

  assign bus.in_ready    = ~pending;
  assign bus.sel         = sel_q;
  assign bus.nib         = active[sel_q];
  assign bus.frame_start = (sel_q == '0) && (cnt == '0);
  assign bus.blank       = (state == BLANKING) ||
                           (bus.lz_en && (sel_q != '0) && zero_from[sel_q]);
endmodule

// File: doc/display_scanner.md
DISPLAY_SCANNER -- requirements
Module: display_scanner

Interface
REQ-001 SHALL have parameter DIV, default 50000: clock cycles per digit slot; legal range 4..2^20.
REQ-002 SHALL have parameter BLANK, default 16: cycles blanked at the start of each slot; legal range 1..DIV-1.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1 bit: a new 8-digit value is offered.
REQ-006 SHALL have port in_ready, output, 1 bit: the block can accept in_data.
REQ-007 SHALL have port in_data, input, 32 bits: eight 4-bit digits; digit k is bits 4k+3..4k.
REQ-008 SHALL have port lz_en, input, 1 bit: leading-zero suppression enable, sampled every cycle.
REQ-009 SHALL have port nib, output, 4 bits: code of the current digit, fed to the downstream 7-segment decoder.
REQ-010 SHALL have port sel, output, 3 bits: index of the current digit, fed to the downstream digit-enable decoder.
REQ-011 SHALL have port blank, output, 1 bit: when 1, the downstream stage turns all digits off.
REQ-012 SHALL have port frame_start, output, 1 bit: single-cycle pulse marking the first cycle of the digit-0 slot.

Function
REQ-013 SHALL keep slot counter cnt, counting 0..DIV-1 and wrapping to 0; a "tick" is the cycle with cnt==DIV-1.
REQ-014 SHALL increment sel on each tick, wrapping from 7 to 0.
REQ-015 SHALL run a per-slot FSM with states BLANKING (cnt<BLANK) and SHOWING (cnt>=BLANK).
REQ-016 SHALL move from BLANKING to SHOWING when cnt reaches BLANK, and from SHOWING to BLANKING on tick.
REQ-017 SHALL hold a 32-bit shadow register, a 32-bit active register and a pending flag.
REQ-018 SHALL drive in_ready = ~pending, combinationally.
REQ-019 SHALL, on in_valid & in_ready, load shadow with in_data and set pending to 1.
REQ-020 SHALL define the frame boundary as a tick with sel==7.
REQ-021 SHALL, at a frame boundary with pending==1, copy shadow to active and clear pending; the new value first appears at sel==0.
REQ-022 SHALL, for an accept in the same cycle as a frame boundary (pending was 0), keep the new value pending until the next boundary.
REQ-023 SHALL drive nib = active[4*sel+3 : 4*sel] combinationally, with zero latency from sel.
REQ-024 SHALL drive blank = 1 in BLANKING.
REQ-025 SHALL also drive blank = 1 in SHOWING when lz_en==1, sel!=0, and every digit at index >= sel is 0 (leading-zero suppression); digit 0 is never suppressed.
REQ-026 SHALL otherwise drive blank = 0.
REQ-027 SHALL drive frame_start = 1 exactly when sel==0 and cnt==0.
REQ-028 SHALL never change active except at a frame boundary, so no displayed frame mixes two values.

Reset
REQ-029 SHALL, while rst==1 at a clock edge, set cnt=0, sel=0, state=BLANKING, shadow=0, active=0 and pending=0.
REQ-030 SHALL therefore give these output values after reset: in_ready=1, nib=0, sel=0, blank=1, and frame_start=1 in the first cycle after reset.
REQ-031 SHALL, when reset is asserted mid-frame or mid-handshake, discard the pending value and the partial slot with no further output effect.

Structure
REQ-032 SHALL take DIGITS=8, NIB_W=4, SEL_W=3 and the FSM state enum (BLANKING, SHOWING) from shared package display_pkg.
REQ-033 SHALL place cnt and tick generation in one sub-module, slot_timer, parameterised by DIV, outputting cnt and tick.

Verification (DIV=8, BLANK=2)
REQ-034 SHALL check: release reset, no input -> sel steps 0..7 every 8 cycles; frame_start pulses every 64 cycles; blank=1 on cnt 0-1 of each slot; nib=0.
REQ-035 SHALL check: accept 0x87654321 at cycle 3 -> in_ready=0 until the boundary at cycle 63; from cycle 64 on, sel=k shows nib=k+1.
REQ-036 SHALL check: second in_valid while pending -> not accepted; in_data held until in_ready=1; the first value is displayed unaltered for a full frame.
REQ-037 SHALL check: accept in the boundary cycle (cycle 63) -> value is not shown in frame 2 and is shown from cycle 128.
REQ-038 SHALL check: active=0x00000450, lz_en=1 -> blank=1 for all of slots 3..7; slots 0..2 show 0, 5, 4 after BLANKING; with lz_en=0 all slots show.
REQ-039 SHALL check: rst pulsed at cycle 37 with pending=1 -> next cycle sel=0, cnt=0, in_ready=1, active=0, frame_start=1.
